// File: rtl/microseq_pkg.sv
// microseq_pkg: shared types and constants for the microprogrammed MIPS
// control unit's next-state logic.
//   STATE_W            - width of a microstate
//   ustate_t           - microstate type
//   ns_sel_e           - next-state mode encodings driven by the microstore
//   COND_*             - bit positions inside cond_in
//   state_inc()        - microstate + 1 with a carry bit, so 127 + 1 is
//                        visible as out of range
package microseq_pkg;

    localparam int STATE_W = 7;

    typedef logic [STATE_W-1:0] ustate_t;

    typedef enum logic [2:0] {
        NS_DISPATCH = 3'd0,
        NS_ZERO     = 3'd1,
        NS_JUMP     = 3'd2,
        NS_INC      = 3'd3,
        NS_CBR      = 3'd4,
        NS_WAIT     = 3'd5,
        NS_CALL     = 3'd6,
        NS_RET      = 3'd7
    } ns_sel_e;

    localparam logic [1:0] COND_MOC = 2'd0;
    localparam logic [1:0] COND_Z   = 2'd1;
    localparam logic [1:0] COND_N   = 2'd2;
    localparam logic [1:0] COND_BR  = 2'd3;

    function automatic logic [STATE_W:0] state_inc(input ustate_t s);
        return {1'b0, s} + (STATE_W+1)'(1);
    endfunction

endpackage

// File: rtl/microseq_stack.sv
// microseq_stack: micro-subroutine return stack (LIFO).
// Only instantiated when MICROSEQ_STACK_EN is defined.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   push, pop       - requests (never both in one cycle; caller gates hold)
//   push_data       - return address to save
//   pop_data        - top-of-stack entry (valid when empty = 0)
//   depth           - occupancy 0..DEPTH
//   empty           - depth == 0
//   err             - sticky: push while full or pop while empty
module microseq_stack
    import microseq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = STATE_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic [3:0]       depth,
    output logic             empty,
    output logic             err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] FULL_CNT = 4'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             full;
    logic             do_push;
    logic             do_pop;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    assign full    = (depth == FULL_CNT);
    assign empty   = (depth == 4'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // depth is a power of two, so the low bits of the occupancy are the
    // next free slot and one below it is the top entry.
    assign wr_idx   = depth[AW-1:0];
    assign rd_idx   = wr_idx - AW'(1);
    assign pop_data = mem[rd_idx];

    // Contents are don't-care after reset, so storage has no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            depth <= 4'd0;
            err   <= 1'b0;
        end else begin
            if (do_push) begin
                depth <= depth + 4'd1;
            end else if (do_pop) begin
                depth <= depth - 4'd1;
            end
            if ((push && full) || (pop && empty)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/microsequencer.sv
// microsequencer: next-state controller for the microprogrammed MIPS
// control unit. Selects the next microstate from dispatch / zero / jump /
// increment / conditional branch / memory wait / call / return, range-checks
// it against LAST_STATE and registers it.
// Optional feature macro: MICROSEQ_STACK_EN builds the return stack; without
// it CALL acts as JUMP, RET acts as ZERO, depth = 0 and stack_err = 0.
// Ports:
//   clk, reset   - clock, asynchronous active-low reset
//   hold         - stall: state, stack and depth frozen, illegal forced low
//   ns_sel       - next-state mode (ns_sel_e)
//   cond_sel     - selects a bit of cond_in; cond_inv inverts it
//   cr           - constant target from the microstore
//   cond_in      - {BR, N, Z, MOC}
//   enc_state    - dispatch target from the instruction encoder
//   state        - registered current microstate
//   illegal      - one-cycle pulse: out-of-range target forced to 0
//   stack_err    - sticky stack overflow/underflow
//   depth        - stack occupancy
module microsequencer
    import microseq_pkg::*;
#(
    parameter int LAST_STATE  = 44,
    parameter int STACK_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         hold,
    input  logic [2:0]   ns_sel,
    input  logic [1:0]   cond_sel,
    input  logic         cond_inv,
    input  logic [6:0]   cr,
    input  logic [3:0]   cond_in,
    input  logic [6:0]   enc_state,
    output logic [6:0]   state,
    output logic         illegal,
    output logic         stack_err,
    output logic [3:0]   depth
);

    localparam logic [STATE_W:0] LAST_TGT = (STATE_W+1)'(LAST_STATE);

    if (STACK_DEPTH < 2 || STACK_DEPTH > 8) begin : g_bad_depth
        $error("microsequencer: STACK_DEPTH must be 2..8");
    end

    logic             c;
    logic [STATE_W:0] inc;
    logic [STATE_W:0] target;
    logic             out_of_range;
    ustate_t          next_state;

    assign c   = cond_in[cond_sel] ^ cond_inv;
    assign inc = state_inc(state);

`ifdef MICROSEQ_STACK_EN
    logic    push;
    logic    pop;
    logic    stk_empty;
    ustate_t pop_data;

    assign push = !hold && (ns_sel == NS_CALL);
    assign pop  = !hold && (ns_sel == NS_RET);

    microseq_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (STATE_W)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (inc[STATE_W-1:0]),
        .pop_data  (pop_data),
        .depth     (depth),
        .empty     (stk_empty),
        .err       (stack_err)
    );
`else
    assign depth     = 4'd0;
    assign stack_err = 1'b0;
`endif

    always_comb begin
        target = '0;
        case (ns_sel_e'(ns_sel))
            NS_DISPATCH: target = {1'b0, enc_state};
            NS_ZERO:     target = '0;
            NS_JUMP:     target = {1'b0, cr};
            NS_INC:      target = inc;
            NS_CBR:      target = c ? {1'b0, cr} : inc;
            NS_WAIT:     target = c ? inc : {1'b0, state};
            NS_CALL:     target = {1'b0, cr};
`ifdef MICROSEQ_STACK_EN
            // Underflow returns to microstate 0, the fetch entry.
            NS_RET:      target = stk_empty ? '0 : {1'b0, pop_data};
`else
            NS_RET:      target = '0;
`endif
            default:     target = '0;
        endcase
    end

    assign out_of_range = (target > LAST_TGT);
    assign next_state   = out_of_range ? '0 : target[STATE_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= '0;
            illegal <= 1'b0;
        end else if (hold) begin
            illegal <= 1'b0;
        end else begin
            state   <= next_state;
            illegal <= out_of_range;
        end
    end

endmodule

// File: doc/microsequencer.md
# microsequencer

Next-state controller for the microprogrammed MIPS control unit. Each cycle it takes the next-state control fields the microstore emits for the current microstate, together with datapath condition flags and the instruction-decoder dispatch address, and registers the next 7-bit microstate. That microstate feeds the microstore's `currentState` input. Sequencing options are dispatch, jump, increment, conditional branch, memory-wait loop, and an optional micro-subroutine call/return stack.

## Interface
- `LAST_STATE`, default 44: highest legal microstate. Any computed target above it is illegal.
- `STACK_DEPTH`, default 4: return-stack entries (power of two, 2 to 8). Used only with `MICROSEQ_STACK_EN`.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low.
- `hold` input, 1 bit: stall. When 1, all state freezes.
- `ns_sel` input, 3 bits: next-state mode, from the microstore.
- `cond_sel` input, 2 bits: selects one bit of `cond_in`.
- `cond_inv` input, 1 bit: inverts the selected condition.
- `cr` input, 7 bits: constant target microstate, from the microstore.
- `cond_in` input, 4 bits: bit 0 MOC, bit 1 ALU zero, bit 2 ALU negative, bit 3 branch-condition unit.
- `enc_state` input, 7 bits: dispatch microstate from the instruction encoder.
- `state` output, 7 bits: registered current microstate, driven to the microstore.
- `illegal` output, 1 bit: one-cycle pulse when a target was out of range.
- `stack_err` output, 1 bit: sticky overflow/underflow flag.
- `depth` output, 4 bits: current stack occupancy (0 when the stack is compiled out).

## Operation
- Condition: `c = cond_in[cond_sel] ^ cond_inv`.
- `inc = state + 1`, computed at 8 bits, so 127+1 = 128 is out of range.
- Target by `ns_sel`:
  - 0 DISPATCH: `enc_state`
  - 1 ZERO: 0
  - 2 JUMP: `cr`
  - 3 INC: `inc`
  - 4 CBR: `c ? cr : inc`
  - 5 WAIT: `c ? inc : state` (memory wait on MOC)
  - 6 CALL: push `inc`, go to `cr`
  - 7 RET: pop, go to the popped entry
- Range check: any target > `LAST_STATE` loads 0 and asserts `illegal` for the cycle after the edge. The stack still updates for CALL; RET has already popped.
- Stack (with macro):
  - CALL when `depth == STACK_DEPTH`: no push, jump still taken, `stack_err` set.
  - RET when `depth == 0`: no pop, state goes to 0, `stack_err` set.
  - LIFO order; `depth` changes by exactly 1 per valid CALL/RET.
- `hold` = 1: `state`, stack, and `depth` unchanged, `illegal` = 0, `stack_err` retained.
- Reset values: `state` = 0, `illegal` = 0, `stack_err` = 0, `depth` = 0, stack contents don't-care. Reset asserted mid-WAIT or mid-subroutine discards everything immediately, without waiting for `clk`.
- `stack_err` is cleared only by reset.

## Timing
- The next-state path is combinational from inputs plus `state`; `state` registers on the rising `clk`. One microinstruction per cycle, zero extra latency.
- `illegal` is registered and aligned with the cycle in which `state` = 0 was loaded.
- The microstore decode of `state` must settle within the same cycle. This block assumes the microstore is combinational.
- Reset deassertion is synchronised by the top level; the first active edge after release evaluates from state 0.

## Configuration
- `MICROSEQ_STACK_EN` defined: return stack is built as specified.
- `MICROSEQ_STACK_EN` undefined: no stack storage.
  - CALL behaves as JUMP.
  - RET behaves as ZERO.
  - `depth` is tied to 0 and `stack_err` to 0.

## Structure
- Package `microseq_pkg` holds:
  - `ns_sel` encodings NS_DISPATCH … NS_RET
  - cond bit indices COND_MOC, COND_Z, COND_N, COND_BR
  - `STATE_W` = 7
  - a typedef for the microstate
- Sub-module `microseq_stack` implements the LIFO: push/pop/data/depth/err. It is instantiated only under the macro.
- The top level holds the target mux, range check, and state register.

## Test plan
- Reset low with `state` = 9 → `state` = 0, `illegal` = 0, `depth` = 0 asynchronously. Release, then `ns_sel`=3 → `state` = 1.
- `state`=2, `ns_sel`=5, `cond_sel`=0, MOC low for 3 cycles then high → `state` holds 2 for 3 cycles, then becomes 3.
- `ns_sel`=4, `cond_sel`=1, `cond_inv`=1, ALU zero = 0, `cr`=30 at `state`=12 → `state` = 30; with ALU zero = 1 → `state` = 13.
- `ns_sel`=0, `enc_state`=50 → `state` = 0, `illegal` pulses one cycle. Also `state`=44, INC → 0 with `illegal`.
- Macro on:
  - CALL `cr`=20 from state 10 → 20, `depth` 1.
  - RET → 11, `depth` 0.
  - Five nested CALLs → `depth` 4, `stack_err` = 1.
  - RET at `depth` 0 → 0, `stack_err` stays set.
- `hold`=1 during CALL → `state`/`depth` unchanged. Macro off: CALL `cr`=20 → 20, RET → 0, `depth` = 0.
